joy_shift_rx: RTL and testbench

JOY_SHIFT_RX -- requirements
Module: joy_shift_rx

---
 rtl/joy_shift_rx.sv | 124 ++++++++++++
 tb/tb_joy_shift_rx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/joy_shift_rx.sv
// joy_shift_rx: receiver for daisy-chained serial joystick adapters.
// Each frame does a parallel load, shifts PLAYERS*BITS bits (bit 0 first),
// then spends a single DONE cycle publishing the decoded buttons.
// joy_clk and joy_load are registered from the next state, so they line up
// exactly with the state the FSM is in and cannot glitch.
module joy_shift_rx #(
  parameter int PLAYERS = 2,
  parameter int BITS    = 12,
  parameter int CLK_DIV = 8,
  parameter int FILTER  = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       joy_data,
  output logic                       joy_clk,
  output logic                       joy_load,
  output logic [PLAYERS*BITS-1:0]    joystick,
  output logic                       frame_done,
  output logic                       changed,
  output logic [2:0]                 o_dbg_state
);

  localparam int TOTAL = PLAYERS * BITS;
  localparam int IW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(TOTAL - 1);
  localparam logic [7:0]    TICK_MAX = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_LOW  = 3'd2,
    S_HIGH = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_tick;
  logic [IW-1:0]     r_index;
  logic [TOTAL-1:0]  r_frame;
  logic [TOTAL-1:0]  r_prev;
  logic              w_tick;
  logic              w_last;
  logic              w_enter_done;
  logic              w_update;

  // Tick strobe only exists while a timed state is active.
  assign w_tick = ((r_state == S_LOAD) || (r_state == S_LOW) || (r_state == S_HIGH)) &&
                  (r_tick == TICK_MAX);
  assign w_last       = (r_index == LAST_IDX);
  assign w_enter_done = (r_state == S_HIGH) && w_tick && w_last;
  // With the filter on, a frame is accepted only if it repeats the previous one.
  assign w_update     = (FILTER == 0) || (r_frame == r_prev);
  assign o_dbg_state  = r_state;

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (enable) w_next = S_LOAD;
      S_LOAD: if (w_tick) w_next = S_LOW;
      S_LOW:  if (w_tick) w_next = S_HIGH;
      S_HIGH: if (w_tick) w_next = w_last ? S_DONE : S_LOW;
      S_DONE: w_next = enable ? S_LOAD : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Tick counter: held at zero in IDLE/DONE, wraps on every tick strobe.
  always_ff @(posedge clk) begin
    if (!reset_n)                                      r_tick <= 8'd0;
    else if ((r_state == S_IDLE) || (r_state == S_DONE) || w_tick) r_tick <= 8'd0;
    else                                               r_tick <= r_tick + 8'd1;
  end

  // Bit index: cleared at the end of LOAD, advanced at the end of each HIGH.
  always_ff @(posedge clk) begin
    if (!reset_n)                                r_index <= '0;
    else if ((r_state == S_LOAD) && w_tick)      r_index <= '0;
    else if ((r_state == S_HIGH) && w_tick && !w_last) r_index <= r_index + 1'b1;
  end

  // Frame shift buffer: sample the (active-low) wire at the end of each LOW.
  always_ff @(posedge clk) begin
    if (!reset_n)                           r_frame <= '0;
    else if ((r_state == S_LOW) && w_tick)  r_frame[r_index] <= ~joy_data;
  end

  // Publish on entry to DONE so joystick, frame_done and changed appear together.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_prev     <= '0;
      joystick   <= '0;
      frame_done <= 1'b0;
      changed    <= 1'b0;
    end else begin
      frame_done <= w_enter_done;
      changed    <= w_enter_done && w_update && (r_frame != joystick);
      if (w_enter_done) begin
        r_prev <= r_frame;
        if (w_update) joystick <= r_frame;
      end
    end
  end

  // Adapter strobes, registered from the next state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      joy_clk  <= 1'b1;
      joy_load <= 1'b1;
    end else begin
      joy_clk  <= (w_next != S_LOW);
      joy_load <= (w_next != S_LOAD);
    end
  end

endmodule

// File: tb/tb_joy_shift_rx.sv
// Bench for joy_shift_rx: three instances (filterless 2x12, filtered 2x12,
// minimal 1x1) share one clock and reset; shift-register adapter models feed
// the two wide instances.
module tb_joy_shift_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n = 1'b0;
  logic en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;
  logic jdata_a, jdata_b, jdata_c;

  logic jclk_a, jload_a, fd_a, ch_a;
  logic jclk_b, jload_b, fd_b, ch_b;
  logic jclk_c, jload_c, fd_c, ch_c;
  logic [23:0] joy_a, joy_b;
  logic [0:0]  joy_c;
  logic [2:0]  dbg_a, dbg_b, dbg_c;

  int n_vec = 0;
  int n_err = 0;
  int overlap = 0;
  int load_low_a = 0;

  joy_shift_rx #(.PLAYERS(2), .BITS(12), .CLK_DIV(4), .FILTER(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .enable(en_a), .joy_data(jdata_a),
    .joy_clk(jclk_a), .joy_load(jload_a), .joystick(joy_a),
    .frame_done(fd_a), .changed(ch_a), .o_dbg_state(dbg_a));

  joy_shift_rx #(.PLAYERS(2), .BITS(12), .CLK_DIV(4), .FILTER(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(en_b), .joy_data(jdata_b),
    .joy_clk(jclk_b), .joy_load(jload_b), .joystick(joy_b),
    .frame_done(fd_b), .changed(ch_b), .o_dbg_state(dbg_b));

  joy_shift_rx #(.PLAYERS(1), .BITS(1), .CLK_DIV(2), .FILTER(0)) dut_c (
    .clk(clk), .reset_n(reset_n), .enable(en_c), .joy_data(jdata_c),
    .joy_clk(jclk_c), .joy_load(jload_c), .joystick(joy_c),
    .frame_done(fd_c), .changed(ch_c), .o_dbg_state(dbg_c));

  // Adapter models: latch buttons while load is low, shift on joy_clk rise.
  logic [23:0] pat_a = '0, sh_a = '0, pat_b = '0, sh_b = '0;
  logic pclk_a = 1'b1, pclk_b = 1'b1;
  always @(posedge clk) begin
    if (!jload_a) sh_a <= pat_a;
    else if (jclk_a && !pclk_a) sh_a <= sh_a >> 1;
    pclk_a <= jclk_a;
    if (!jload_b) sh_b <= pat_b;
    else if (jclk_b && !pclk_b) sh_b <= sh_b >> 1;
    pclk_b <= jclk_b;
  end
  assign jdata_a = ~sh_a[0];
  assign jdata_b = ~sh_b[0];

  // Strobe legality and load-width monitors.
  always @(negedge clk) begin
    if ((!jclk_a && !jload_a) || (!jclk_b && !jload_b) || (!jclk_c && !jload_c))
      overlap++;
    if (!jload_a) load_low_a++;
  end

  task automatic wait_done(input int d, input int budget, output int cycles, output bit ok);
    cycles = 0;
    ok = 1'b0;
    while ((cycles < budget) && !ok) begin
      @(negedge clk);
      cycles++;
      case (d)
        0:       ok = (fd_a === 1'b1);
        1:       ok = (fd_b === 1'b1);
        default: ok = (fd_c === 1'b1);
      endcase
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if ({joy_a, joy_b, joy_c} !== 49'd0) begin n_err++; $display("FAIL reset_joystick got %h want 0", {joy_a, joy_b, joy_c}); end
    n_vec++; if ({jclk_a, jclk_b, jclk_c} !== 3'b111) begin n_err++; $display("FAIL reset_joy_clk got %b want 111", {jclk_a, jclk_b, jclk_c}); end
    n_vec++; if ({jload_a, jload_b, jload_c} !== 3'b111) begin n_err++; $display("FAIL reset_joy_load got %b want 111", {jload_a, jload_b, jload_c}); end
    n_vec++; if ({fd_a, fd_b, fd_c, ch_a, ch_b, ch_c} !== 6'd0) begin n_err++; $display("FAIL reset_pulses got %b want 000000", {fd_a, fd_b, fd_c, ch_a, ch_b, ch_c}); end
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    n_vec++; if ({jclk_a, jload_a, fd_a} !== 3'b110) begin n_err++; $display("FAIL idle_hold got %b want 110", {jclk_a, jload_a, fd_a}); end
  endtask

  task automatic test_basic();
    int cyc; bit ok;
    pat_a = 24'h3C00A5;
    en_a = 1'b1;
    wait_done(0, 400, cyc, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL basic_timeout got %0d cycles want done", cyc); end
    n_vec++; if (ch_a !== 1'b1) begin n_err++; $display("FAIL basic_changed got %b want 1", ch_a); end
    load_low_a = 0;
    @(negedge clk);
    n_vec++; if (joy_a !== 24'h3C00A5) begin n_err++; $display("FAIL basic_joystick got %h want 3c00a5", joy_a); end
    wait_done(0, 400, cyc, ok);
    n_vec++; if (!ok || (cyc + 1 != 197)) begin n_err++; $display("FAIL basic_period got %0d want 197", cyc + 1); end
    n_vec++; if (load_low_a != 4) begin n_err++; $display("FAIL basic_load_width got %0d want 4", load_low_a); end
    n_vec++; if (ch_a !== 1'b0) begin n_err++; $display("FAIL basic_repeat_changed got %b want 0", ch_a); end
    @(negedge clk);
  endtask

  task automatic test_random();
    int cyc; bit ok;
    logic [23:0] model_joy;
    model_joy = 24'h3C00A5;
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 3) != 0) pat_a = 24'($urandom);
      wait_done(0, 400, cyc, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL rand_timeout[%0d] got %0d cycles want done", i, cyc); end
      n_vec++; if (ch_a !== (pat_a != model_joy)) begin n_err++; $display("FAIL rand_changed[%0d] got %b want %b", i, ch_a, pat_a != model_joy); end
      model_joy = pat_a;
      @(negedge clk);
      n_vec++; if (joy_a !== model_joy) begin n_err++; $display("FAIL rand_joystick[%0d] got %h want %h", i, joy_a, model_joy); end
    end
  endtask

  task automatic test_enable_drop();
    int cyc; bit ok; int bad; int extra;
    logic [23:0] old;
    old = pat_a;
    pat_a = old ^ 24'h5A5A5A;
    repeat (44) @(negedge clk);
    en_a = 1'b0;
    wait_done(0, 300, cyc, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL drop_timeout got %0d cycles want done", cyc); end
    n_vec++; if (ch_a !== 1'b1) begin n_err++; $display("FAIL drop_changed got %b want 1", ch_a); end
    @(negedge clk);
    n_vec++; if (joy_a !== pat_a) begin n_err++; $display("FAIL drop_joystick got %h want %h", joy_a, pat_a); end
    bad = 0; extra = 0;
    repeat (120) begin
      @(negedge clk);
      if (fd_a) extra++;
      if (!jclk_a || !jload_a) bad++;
    end
    n_vec++; if (extra != 0) begin n_err++; $display("FAIL drop_extra_done got %0d want 0", extra); end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL drop_idle_strobes got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_filter();
    int cyc; bit ok; bit upd; bit exp_ch;
    logic [23:0] model_joy, model_prev, pats[4];
    pats[0] = 24'h000001; pats[1] = 24'h000001; pats[2] = 24'h000002; pats[3] = 24'h000002;
    model_joy = '0; model_prev = '0;
    en_b = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i < 4) pat_b = pats[i];
      else if ($urandom_range(0, 1) == 0) pat_b = 24'($urandom);
      wait_done(1, 400, cyc, ok);
      upd = (pat_b == model_prev);
      exp_ch = upd && (pat_b != model_joy);
      if (upd) model_joy = pat_b;
      model_prev = pat_b;
      n_vec++; if (!ok) begin n_err++; $display("FAIL filt_timeout[%0d] got %0d cycles want done", i, cyc); end
      n_vec++; if (ch_b !== exp_ch) begin n_err++; $display("FAIL filt_changed[%0d] got %b want %b", i, ch_b, exp_ch); end
      @(negedge clk);
      n_vec++; if (joy_b !== model_joy) begin n_err++; $display("FAIL filt_joystick[%0d] got %h want %h", i, joy_b, model_joy); end
    end
    en_b = 1'b0;
  endtask

  task automatic test_single();
    int cyc; bit ok;
    jdata_c = 1'b0;
    en_c = 1'b1;
    wait_done(2, 50, cyc, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL single_timeout got %0d cycles want done", cyc); end
    n_vec++; if (ch_c !== 1'b1) begin n_err++; $display("FAIL single_first_changed got %b want 1", ch_c); end
    @(negedge clk);
    n_vec++; if (joy_c !== 1'b1) begin n_err++; $display("FAIL single_joystick got %b want 1", joy_c); end
    for (int i = 0; i < 3; i++) begin
      wait_done(2, 20, cyc, ok);
      n_vec++; if (!ok || (cyc + 1 != 7)) begin n_err++; $display("FAIL single_period[%0d] got %0d want 7", i, cyc + 1); end
      n_vec++; if (ch_c !== 1'b0) begin n_err++; $display("FAIL single_changed[%0d] got %b want 0", i, ch_c); end
      @(negedge clk);
    end
    en_c = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cyc; bit ok; int n; int extra;
    en_a = 1'b1;
    pat_a = 24'($urandom) | 24'h1;
    wait_done(0, 400, cyc, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL rmid_timeout got %0d cycles want done", cyc); end
    n = 0;
    while ((jclk_a !== 1'b0) && (n < 100)) begin @(negedge clk); n++; end
    while ((jclk_a !== 1'b1) && (n < 100)) begin @(negedge clk); n++; end
    n_vec++; if (n >= 100) begin n_err++; $display("FAIL rmid_find_high got %0d cycles want <100", n); end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    n_vec++; if (joy_a !== 24'd0) begin n_err++; $display("FAIL rmid_joystick got %h want 0", joy_a); end
    n_vec++; if ({jclk_a, jload_a, fd_a, ch_a} !== 4'b1100) begin n_err++; $display("FAIL rmid_strobes got %b want 1100", {jclk_a, jload_a, fd_a, ch_a}); end
    extra = 0;
    repeat (30) begin @(negedge clk); if (fd_a) extra++; end
    n_vec++; if (extra != 0) begin n_err++; $display("FAIL rmid_no_done got %0d want 0", extra); end
    en_a = 1'b0;
  endtask

  task automatic test_legal_strobes();
    n_vec++; if (overlap != 0) begin n_err++; $display("FAIL strobe_overlap got %0d want 0", overlap); end
  endtask

  initial begin
    jdata_c = 1'b1;
    test_reset();
    test_basic();
    test_random();
    test_enable_drop();
    test_filter();
    test_single();
    test_reset_mid();
    test_legal_strobes();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
